// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART transceiver with optional internal loopback.
//
// Optional feature: define UART_PARITY_EN to add a parity bit to every frame
// (even when PARITY_ODD=0, odd when PARITY_ODD=1). Without it, frames carry
// no parity bit and parity_err_o is tied low.
//
// Ports:
//   clk_i          single clock
//   rst_i          synchronous active-high reset
//   tx_start_i     send request, sampled only while TX is idle
//   tx_byte_i      data to transmit, LSB first
//   loopback_i     1: RX listens to the internal TX line, 0: RX uses rx_serial_i
//   rx_serial_i    external serial input (asynchronous)
//   tx_serial_o    serial output, idle high
//   tx_active_o    high while a frame is being shifted out
//   tx_done_o      one-cycle pulse at frame end
//   data_valid_o   one-cycle pulse when a received frame is available
//   rx_byte_o      last received data, held until the next data_valid_o
//   framing_err_o  stop bit sampled low (qualified by data_valid_o)
//   parity_err_o   parity mismatch (qualified by data_valid_o)
module uart_xcvr #(
    parameter int unsigned CLKS_PER_BIT = 2000000,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tx_start_i,
    input  logic [DATA_BITS-1:0] tx_byte_i,
    input  logic                 loopback_i,
    input  logic                 rx_serial_i,
    output logic                 tx_serial_o,
    output logic                 tx_active_o,
    output logic                 tx_done_o,
    output logic                 data_valid_o,
    output logic [DATA_BITS-1:0] rx_byte_o,
    output logic                 framing_err_o,
    output logic                 parity_err_o
);

    localparam int unsigned CntW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
    localparam int unsigned IdxW = $clog2(DATA_BITS);
    localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);
    // The done/idle cycle after STOP supplies the final stop-bit cycle, so
    // back-to-back frames have no extra high cycle between them.
    localparam logic [CntW-1:0] StopEnd = CntW'(STOP_BITS * CLKS_PER_BIT - 2);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 ||
        STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_xcvr: illegal parameter value");
    end

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxDone} rx_state_e;

    // ---------------- Transmitter ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [IdxW-1:0]      tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 tx_done_q, tx_done_d;
    logic                 tx_line;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_data_d  = tx_data_q;
        tx_done_d  = 1'b0;
        tx_line    = 1'b1;
        unique case (tx_state_q)
            TxIdle: begin
                if (tx_start_i) begin
                    tx_data_d  = tx_byte_i;
                    tx_cnt_d   = '0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                tx_line = 1'b0;
                if (tx_cnt_q == BitEnd) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TxData: begin
                tx_line = tx_data_q[tx_idx_q];
                if (tx_cnt_q == BitEnd) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == LastIdx) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TxParity;
`else
                        tx_state_d = TxStop;
`endif
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            TxParity: begin
                tx_line = (^tx_data_q) ^ 1'(PARITY_ODD);
                if (tx_cnt_q == BitEnd) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TxStop;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
`endif
            TxStop: begin
                if (tx_cnt_q == StopEnd) begin
                    tx_done_d  = 1'b1;
                    tx_state_d = TxIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_data_q  <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_data_q  <= tx_data_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx_serial_o = tx_line;
    assign tx_active_o = (tx_state_q != TxIdle);
    assign tx_done_o   = tx_done_q;

    // ---------------- Receiver ----------------
    rx_state_e            rx_state_q, rx_state_d;
    logic [1:0]           rx_sync_q;
    logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
    logic [IdxW-1:0]      rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                 ferr_q, ferr_d;
    logic                 wait_high_q, wait_high_d;
    logic                 perr_q, perr_d;
    logic                 rx_in;

    assign rx_in = rx_sync_q[1];

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_idx_d    = rx_idx_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        ferr_d      = ferr_q;
        wait_high_d = wait_high_q;
        perr_d      = perr_q;
        unique case (rx_state_q)
            RxIdle: begin
                // After a framing error the line must go high before a new start.
                if (rx_in) begin
                    wait_high_d = 1'b0;
                end else if (!wait_high_q) begin
                    rx_cnt_d   = '0;
                    perr_d     = 1'b0;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfEnd) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_in ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == BitEnd) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_in, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == LastIdx) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RxParity;
`else
                        rx_state_d = RxStop;
`endif
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            RxParity: begin
                if (rx_cnt_q == BitEnd) begin
                    rx_cnt_d   = '0;
                    perr_d     = rx_in ^ (^rx_shift_q) ^ 1'(PARITY_ODD);
                    rx_state_d = RxStop;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
`endif
            RxStop: begin
                if (rx_cnt_q == BitEnd) begin
                    ferr_d      = !rx_in;
                    wait_high_d = !rx_in;
                    rx_byte_d   = rx_shift_q;
                    rx_state_d  = RxDone;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxDone:  rx_state_d = RxIdle;
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state_q  <= RxIdle;
            rx_sync_q   <= 2'b11;
            rx_cnt_q    <= '0;
            rx_idx_q    <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            ferr_q      <= 1'b0;
            wait_high_q <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_sync_q   <= {rx_sync_q[0], loopback_i ? tx_line : rx_serial_i};
            rx_cnt_q    <= rx_cnt_d;
            rx_idx_q    <= rx_idx_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            ferr_q      <= ferr_d;
            wait_high_q <= wait_high_d;
            perr_q      <= perr_d;
        end
    end

    assign data_valid_o  = (rx_state_q == RxDone);
    assign rx_byte_o     = rx_byte_q;
    assign framing_err_o = data_valid_o & ferr_q;
`ifdef UART_PARITY_EN
    assign parity_err_o  = data_valid_o & perr_q;
`else
    assign parity_err_o  = 1'b0;
`endif

endmodule

// File: doc/uart_xcvr.md
UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 Parameter CLKS_PER_BIT, default 2000000: Clk cycles per serial bit; legal range >= 4.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter STOP_BITS, default 1: stop bits transmitted; legal values 1 or 2.
REQ-004 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; used only when UART_PARITY_EN is defined.
REQ-005 Clk  in  1  single clock for all logic.
REQ-006 Rst  in  1  reset; synchronous, active-high.
REQ-007 Tx_Start  in  1  request to send Tx_Byte; sampled only in TX IDLE.
REQ-008 Tx_Byte  in  DATA_BITS  data to transmit; LSB first.
REQ-009 Loopback  in  1  1 = RX input is the internal TX line; 0 = RX input is Rx_Serial.
REQ-010 Rx_Serial  in  1  external serial input; asynchronous to Clk.
REQ-011 Tx_Serial  out  1  serial output; idle high.
REQ-012 Tx_Active  out  1  high while a frame is being shifted out.
REQ-013 Tx_Done  out  1  one-cycle pulse at frame end.
REQ-014 Data_Valid  out  1  one-cycle pulse when a received frame is available.
REQ-015 Rx_Byte  out  DATA_BITS  last received data; held until the next Data_Valid.
REQ-016 Framing_Err  out  1  qualified by Data_Valid; stop bit sampled low.
REQ-017 Parity_Err  out  1  qualified by Data_Valid; parity mismatch.

Function
REQ-018 TX FSM states: IDLE, START, DATA, PARITY, STOP. Each non-IDLE state except STOP lasts CLKS_PER_BIT cycles; STOP lasts STOP_BITS*CLKS_PER_BIT cycles.
REQ-019 In IDLE, Tx_Start=1 latches Tx_Byte. On the next cycle, Tx_Serial=0 and Tx_Active=1.
REQ-020 Tx_Start while Tx_Active=1 is ignored; the frame in flight and its latched data are unaffected.
REQ-021 DATA shifts out bits 0..DATA_BITS-1. PARITY carries XOR(data) for even parity, or its inverse for odd parity. Tx_Serial=1 in STOP.
REQ-022 At the end of STOP, Tx_Active falls and Tx_Done pulses for exactly one cycle in the same cycle. Tx_Start asserted in that same cycle is accepted, so frames can be sent back-to-back.
REQ-023 RX input path: selected line (per REQ-009), then a 2-flop synchroniser; the synchroniser flops reset to 1.
REQ-024 RX FSM states: IDLE, START, DATA, PARITY, STOP, then a one-cycle DONE state.
REQ-025 A synchronised low in IDLE enters START. At CLKS_PER_BIT/2 cycles the line is re-sampled: low continues the frame; high is a glitch and returns to IDLE with no Data_Valid.
REQ-026 Data, parity and the first stop bit are sampled every CLKS_PER_BIT cycles after the mid-start sample. The RX checks only the first stop bit.
REQ-027 In DONE, Rx_Byte updates and Data_Valid pulses for one cycle. Framing_Err and Parity_Err are valid in that cycle and 0 otherwise.
REQ-028 Framing error: the frame is still delivered (Data_Valid=1, Framing_Err=1). RX then waits in IDLE until the line reads high before accepting a new start.
REQ-029 Loopback changing mid-frame: the RX frame content is unspecified, but the RX returns to IDLE within one frame time. TX is unaffected.
REQ-030 Tx_Serial is driven in both Loopback modes.
REQ-031 Baud counters are ceil(log2(STOP_BITS*CLKS_PER_BIT+1)) bits wide and do not wrap within a state.

Reset
REQ-032 Rst=1 at a rising Clk edge forces both FSMs to IDLE and sets Tx_Serial=1. Tx_Active, Tx_Done, Data_Valid, Framing_Err, Parity_Err and Rx_Byte are all set to 0.
REQ-033 Reset mid-frame aborts the frame immediately: no Tx_Done, no Data_Valid. Operation resumes on the first cycle after Rst=0.

Configuration
REQ-034 Macro UART_PARITY_EN defined: PARITY states are present in both FSMs, and Parity_Err reports a mismatch against PARITY_ODD.
REQ-035 UART_PARITY_EN undefined: PARITY states and parity logic are absent, frames carry no parity bit, and Parity_Err is tied 0.

Verification
REQ-036 Default params, CLKS_PER_BIT=4, no parity, Loopback=1, Tx_Byte=8'hA5 pulsed: Tx_Done after 40 cycles; Data_Valid with Rx_Byte=8'hA5 and both errors 0.
REQ-037 UART_PARITY_EN, PARITY_ODD=0, Loopback=0, Rx_Serial driven 0x3C with a wrong parity bit: Data_Valid with Rx_Byte=8'h3C, Parity_Err=1.
REQ-038 Loopback=0, Rx_Serial frame 8'h81 with stop bit=0: Data_Valid, Framing_Err=1; no new start is accepted until the line returns high.
REQ-039 Rx_Serial low pulse of 1 cycle while idle: no Data_Valid; RX back in IDLE.
REQ-040 Tx_Start held high for three consecutive frames (0x01, 0x02, 0x03) in Loopback with STOP_BITS=2: zero idle gap between frames; three Data_Valid pulses in order.
REQ-041 Rst pulsed at cycle 15 of a TX frame: Tx_Serial=1 and Tx_Active=0 next cycle; no Tx_Done or Data_Valid.
